proc_scheduler: RTL and testbench

Run sequencer for the coprocessor's pixel-processing datapath: ROM → processing core → RAMProc frame buffer. It latches algorithm and zoom configuration at run start and holds it stable for the whole run. It sequences the processing-enable handshake, guards runs with a watchdog, and swaps the VGA source from ROM to RAM only at a frame boundary to avoid tearing. It sits between the debouncer/zoom controller (requesters) and the processing core/VGA source mux (consumers).

---
 rtl/coproc_pkg.sv | 26 ++
 rtl/proc_watchdog.sv | 31 +++
 rtl/proc_scheduler.sv | 112 +++++++++++
 tb/tb_proc_scheduler.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor run sequencer: FSM states, config codes
// and VGA source selection values.
package coproc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      RUN,
      SWAP,
      SHOW
   } sched_state_t;

   localparam logic [1:0] ALG_BYPASS = 2'd0;
   localparam logic [1:0] ALG_BLUR   = 2'd1;
   localparam logic [1:0] ALG_EDGE   = 2'd2;
   localparam logic [1:0] ALG_INVERT = 2'd3;

   localparam logic [1:0] ZOOM_X1 = 2'd0;
   localparam logic [1:0] ZOOM_X2 = 2'd1;
   localparam logic [1:0] ZOOM_X4 = 2'd2;
   localparam logic [1:0] ZOOM_X8 = 2'd3;

   localparam logic SRC_ROM = 1'b0;
   localparam logic SRC_RAM = 1'b1;

endpackage

// File: rtl/proc_watchdog.sv
// Run watchdog: counts enabled cycles since the last clear and flags the cycle
// on which the count reaches TIMEOUT_CYCLES-1.
module proc_watchdog #(
   parameter int TIMEOUT_CYCLES = 1_500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CEIL = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] count;

   // Saturates at TIMEOUT_CYCLES so a stray enable can never wrap into a fresh window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (count_en && (count != CEIL))
         count <= count + 1'b1;
   end

   assign expired = count_en && (count == LAST);

endmodule

// File: rtl/proc_scheduler.sv
// Run sequencer for the ROM -> processing core -> RAMProc path: latches config,
// drives the processing-enable handshake, and swaps VGA source at frame start.
module proc_scheduler
   import coproc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_500_000,
   parameter bit AUTO_RERUN     = 1'b1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic [1:0] ALGORITHM_IN,
   input  logic [1:0] ZOOM_LEVEL_IN,
   input  logic       FRAME_START,
   input  logic       PROC_DONE,
   output logic       PROC_ENABLE,
   output logic [1:0] PROC_ALGORITHM,
   output logic [1:0] PROC_ZOOM,
   output logic       VGA_SOURCE_SELECT,
   output logic       BUSY,
   output logic       ERROR,
   output logic [7:0] RUN_COUNT
);

   sched_state_t state, next_state;
   logic         pending, pending_d;
   logic         expired;
   logic         cfg_changed;
   logic         enable_d, vga_d, busy_d, error_d;
   logic [1:0]   alg_d, zoom_d;
   logic [7:0]   count_d;

   proc_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (CLK),
      .rst     (RESET),
      .clear   (state == LATCH),
      .count_en(state == RUN),
      .expired (expired)
   );

   assign cfg_changed = (ALGORITHM_IN != PROC_ALGORITHM) || (ZOOM_LEVEL_IN != PROC_ZOOM);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (START) next_state = LATCH;
         LATCH:   next_state = RUN;
         // A completion arriving on the timeout cycle still counts as success.
         RUN:     if (PROC_DONE) next_state = SWAP;
                  else if (expired) next_state = IDLE;
         SWAP:    if (FRAME_START) next_state = SHOW;
         SHOW:    if (START || pending || (AUTO_RERUN && cfg_changed)) next_state = LATCH;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are decoded from the upcoming state so they settle together with it.
   always_comb begin
      enable_d  = (next_state == RUN);
      vga_d     = (next_state == SHOW) ? SRC_RAM : SRC_ROM;
      busy_d    = (next_state == LATCH) || (next_state == RUN) || (next_state == SWAP);
      alg_d     = PROC_ALGORITHM;
      zoom_d    = PROC_ZOOM;
      error_d   = ERROR;
      pending_d = pending;
      count_d   = RUN_COUNT;
      if (next_state == LATCH) begin
         alg_d     = ALGORITHM_IN;
         zoom_d    = ZOOM_LEVEL_IN;
         error_d   = 1'b0;
         pending_d = 1'b0;
      end
      if ((state == RUN) && expired && !PROC_DONE)
         error_d = 1'b1;
      if ((state == SWAP) && START)
         pending_d = 1'b1;
      if ((state == SWAP) && FRAME_START)
         count_d = RUN_COUNT + 8'd1;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         PROC_ENABLE       <= 1'b0;
         PROC_ALGORITHM    <= ALG_BYPASS;
         PROC_ZOOM         <= ZOOM_X1;
         VGA_SOURCE_SELECT <= SRC_ROM;
         BUSY              <= 1'b0;
         ERROR             <= 1'b0;
         RUN_COUNT         <= 8'd0;
         pending           <= 1'b0;
      end else begin
         PROC_ENABLE       <= enable_d;
         PROC_ALGORITHM    <= alg_d;
         PROC_ZOOM         <= zoom_d;
         VGA_SOURCE_SELECT <= vga_d;
         BUSY              <= busy_d;
         ERROR             <= error_d;
         RUN_COUNT         <= count_d;
         pending           <= pending_d;
      end
   end

endmodule

// File: tb/tb_proc_scheduler.sv
// Bench for proc_scheduler: cycle vectors with expected outputs queued at drive
// time and compared once the DUT has clocked, plus reset/no-rerun/wrap sequences.
module tb_proc_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, fs = 1'b0, done = 1'b0;
   logic [1:0] alg = 2'd0, zoom = 2'd0;

   logic       en, vga, busy, err;
   logic [1:0] p_alg, p_zoom;
   logic [7:0] cnt;
   logic       en_nr, vga_nr, busy_nr, err_nr;
   logic [1:0] p_alg_nr, p_zoom_nr;
   logic [7:0] cnt_nr;

   always #5 clk = ~clk;

   proc_scheduler #(.TIMEOUT_CYCLES(16), .AUTO_RERUN(1'b1)) dut (
      .CLK(clk), .RESET(rst), .START(start), .ALGORITHM_IN(alg), .ZOOM_LEVEL_IN(zoom),
      .FRAME_START(fs), .PROC_DONE(done), .PROC_ENABLE(en), .PROC_ALGORITHM(p_alg),
      .PROC_ZOOM(p_zoom), .VGA_SOURCE_SELECT(vga), .BUSY(busy), .ERROR(err), .RUN_COUNT(cnt)
   );

   proc_scheduler #(.TIMEOUT_CYCLES(16), .AUTO_RERUN(1'b0)) dut_nr (
      .CLK(clk), .RESET(rst), .START(start), .ALGORITHM_IN(alg), .ZOOM_LEVEL_IN(zoom),
      .FRAME_START(fs), .PROC_DONE(done), .PROC_ENABLE(en_nr), .PROC_ALGORITHM(p_alg_nr),
      .PROC_ZOOM(p_zoom_nr), .VGA_SOURCE_SELECT(vga_nr), .BUSY(busy_nr), .ERROR(err_nr),
      .RUN_COUNT(cnt_nr)
   );

   typedef struct packed {
      logic       en;
      logic [1:0] alg;
      logic [1:0] zoom;
      logic       vga;
      logic       busy;
      logic       err;
      logic [7:0] cnt;
   } outs_t;

   typedef struct {
      int         n;
      logic       start;
      logic [1:0] alg;
      logic [1:0] zoom;
      logic       fs;
      logic       done;
      outs_t      e;
   } vec_t;

   vec_t  tbl[$];
   outs_t exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   function automatic outs_t o(bit e, int a, int z, bit v, bit b, bit r, int c);
      outs_t x;
      x.en = e; x.alg = 2'(a); x.zoom = 2'(z); x.vga = v; x.busy = b; x.err = r; x.cnt = 8'(c);
      return x;
   endfunction

   function automatic vec_t v(int n, bit s, int a, int z, bit f, bit d, outs_t e);
      vec_t x;
      x.n = n; x.start = s; x.alg = 2'(a); x.zoom = 2'(z); x.fs = f; x.done = d; x.e = e;
      return x;
   endfunction

   function automatic outs_t got();
      return {en, p_alg, p_zoom, vga, busy, err, cnt};
   endfunction

   function automatic outs_t got_nr();
      return {en_nr, p_alg_nr, p_zoom_nr, vga_nr, busy_nr, err_nr, cnt_nr};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (en,alg,zoom,vga,busy,err,cnt packed)", name, act, exp);
      end
   endtask

   task automatic step(string tag, vec_t r);
      outs_t want;
      for (int k = 0; k < r.n; k++) begin
         @(negedge clk);
         start = r.start; alg = r.alg; zoom = r.zoom; fs = r.fs; done = r.done;
         exp_q.push_back(r.e);
         @(posedge clk);
         #1;
         want = exp_q.pop_front();
         check($sformatf("%s.%0d", tag, k), 32'(got()), 32'(want));
      end
   endtask

   task automatic run_once();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); done = 1'b1;
      @(negedge clk); done = 1'b0; fs = 1'b1;
      @(negedge clk); fs = 1'b0;
   endtask

   initial begin
      // Normal run, coincident done/frame, config ignored in RUN
      tbl.push_back(v( 3, 0, 2, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(v( 1, 1, 2, 1, 0, 0, o(0, 2, 1, 0, 1, 0, 0)));
      tbl.push_back(v( 1, 0, 2, 1, 0, 0, o(1, 2, 1, 0, 1, 0, 0)));
      tbl.push_back(v( 5, 0, 2, 1, 0, 0, o(1, 2, 1, 0, 1, 0, 0)));
      tbl.push_back(v( 1, 1, 3, 0, 0, 0, o(1, 2, 1, 0, 1, 0, 0)));
      tbl.push_back(v( 1, 0, 2, 1, 1, 1, o(0, 2, 1, 0, 1, 0, 0)));
      tbl.push_back(v( 2, 0, 2, 1, 0, 0, o(0, 2, 1, 0, 1, 0, 0)));
      tbl.push_back(v( 1, 0, 2, 1, 1, 0, o(0, 2, 1, 1, 0, 0, 1)));
      tbl.push_back(v( 3, 0, 2, 1, 0, 0, o(0, 2, 1, 1, 0, 0, 1)));
      // Auto rerun on zoom change, then pending start from SWAP
      tbl.push_back(v( 1, 0, 2, 2, 0, 0, o(0, 2, 2, 0, 1, 0, 1)));
      tbl.push_back(v( 1, 0, 2, 2, 0, 0, o(1, 2, 2, 0, 1, 0, 1)));
      tbl.push_back(v( 1, 0, 2, 2, 0, 1, o(0, 2, 2, 0, 1, 0, 1)));
      tbl.push_back(v( 1, 1, 2, 2, 0, 0, o(0, 2, 2, 0, 1, 0, 1)));
      tbl.push_back(v( 1, 0, 2, 2, 1, 0, o(0, 2, 2, 1, 0, 0, 2)));
      tbl.push_back(v( 1, 0, 2, 2, 0, 0, o(0, 2, 2, 0, 1, 0, 2)));
      tbl.push_back(v( 1, 0, 2, 2, 0, 0, o(1, 2, 2, 0, 1, 0, 2)));
      tbl.push_back(v( 1, 0, 2, 2, 0, 1, o(0, 2, 2, 0, 1, 0, 2)));
      tbl.push_back(v( 1, 0, 2, 2, 1, 0, o(0, 2, 2, 1, 0, 0, 3)));
      tbl.push_back(v( 2, 0, 2, 2, 0, 0, o(0, 2, 2, 1, 0, 0, 3)));
      // Timeout after 16 RUN cycles, ERROR cleared by the next LATCH
      tbl.push_back(v( 1, 1, 1, 3, 0, 0, o(0, 1, 3, 0, 1, 0, 3)));
      tbl.push_back(v(16, 0, 1, 3, 0, 0, o(1, 1, 3, 0, 1, 0, 3)));
      tbl.push_back(v( 1, 0, 1, 3, 0, 0, o(0, 1, 3, 0, 0, 1, 3)));
      tbl.push_back(v( 2, 0, 2, 0, 0, 0, o(0, 1, 3, 0, 0, 1, 3)));
      tbl.push_back(v( 1, 1, 1, 3, 0, 0, o(0, 1, 3, 0, 1, 0, 3)));
      // Done on the timeout cycle wins
      tbl.push_back(v(16, 0, 1, 3, 0, 0, o(1, 1, 3, 0, 1, 0, 3)));
      tbl.push_back(v( 1, 0, 1, 3, 0, 1, o(0, 1, 3, 0, 1, 0, 3)));
      tbl.push_back(v( 1, 0, 1, 3, 1, 0, o(0, 1, 3, 1, 0, 0, 4)));

      @(posedge clk); #1;
      check("reset_state", 32'(got()), 32'(o(0, 0, 0, 0, 0, 0, 0)));
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++)
         step($sformatf("vec%0d", i), tbl[i]);

      // Asynchronous reset in the middle of a run
      step("rst_latch", v(1, 1, 1, 3, 0, 0, o(0, 1, 3, 0, 1, 0, 4)));
      step("rst_run",   v(2, 0, 1, 3, 0, 0, o(1, 1, 3, 0, 1, 0, 4)));
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("async_reset", 32'(got()), 32'(o(0, 0, 0, 0, 0, 0, 0)));
      check("async_reset_nr", 32'(got_nr()), 32'(o(0, 0, 0, 0, 0, 0, 0)));
      @(negedge clk); rst = 1'b0;
      step("post_reset_idle", v(2, 0, 1, 3, 0, 0, o(0, 0, 0, 0, 0, 0, 0)));

      // With AUTO_RERUN=0 a config change in SHOW does not start a run
      step("nr_latch", v(1, 1, 0, 1, 0, 0, o(0, 0, 1, 0, 1, 0, 0)));
      step("nr_run",   v(1, 0, 0, 1, 0, 0, o(1, 0, 1, 0, 1, 0, 0)));
      step("nr_swap",  v(1, 0, 0, 1, 0, 1, o(0, 0, 1, 0, 1, 0, 0)));
      step("nr_show",  v(1, 0, 0, 1, 1, 0, o(0, 0, 1, 1, 0, 0, 1)));
      check("nr_show_noauto", 32'(got_nr()), 32'(o(0, 0, 1, 1, 0, 0, 1)));
      step("auto_latch", v(1, 0, 0, 2, 0, 0, o(0, 0, 2, 0, 1, 0, 1)));
      check("noauto_stays_show", 32'(got_nr()), 32'(o(0, 0, 1, 1, 0, 0, 1)));
      step("auto_run", v(1, 0, 0, 2, 0, 0, o(1, 0, 2, 0, 1, 0, 1)));
      check("noauto_still_show", 32'(got_nr()), 32'(o(0, 0, 1, 1, 0, 0, 1)));

      // RUN_COUNT wraps from 255 to 0
      @(negedge clk); rst = 1'b1; alg = 2'd0; zoom = 2'd1;
      @(negedge clk); rst = 1'b0;
      for (int r = 0; r < 255; r++)
         run_once();
      check("count_255", 32'(cnt), 32'd255);
      check("count_255_nr", 32'(cnt_nr), 32'd255);
      step("wrap_latch", v(1, 1, 0, 1, 0, 0, o(0, 0, 1, 0, 1, 0, 255)));
      step("wrap_run",   v(1, 0, 0, 1, 0, 0, o(1, 0, 1, 0, 1, 0, 255)));
      step("wrap_swap",  v(1, 0, 0, 1, 0, 1, o(0, 0, 1, 0, 1, 0, 255)));
      step("wrap_show",  v(1, 0, 0, 1, 1, 0, o(0, 0, 1, 1, 0, 0, 0)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
